// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch controller: default address
//   map, FSM state encodings and the prefetch queue entry layout.
//   Optional feature macro used by the controller: IFU_EXC_EN.
package ifu_fetch_ctrl_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IFU_IM_BASE  = 32'h0000_3000;
    localparam int          IFU_IM_WORDS = 1024;

    // state | meaning
    // RUN   | normal fetching, one enq per cycle while the queue has room
    // HALT  | fetch address error seen; queue drains, waits for redirect
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic        exc;
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ifu_fetch_ctrl_fifo.sv
// ifu_fifo
//   Synchronous DEPTH-entry queue of fetched {exc, pc, inst} entries.
//   Ports:
//     clk, reset_n  clock and asynchronous active-low reset
//     i_push        write i_data at the tail
//     i_pop         drop the head
//     i_flush       discard all entries (overrides push/pop)
//     i_data        entry to push
//     o_head        current head entry (undefined content when empty)
//     o_count       number of valid entries, 0..DEPTH
module ifu_fifo
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic                      i_flush,
    input  fifo_entry_t               i_data,
    output fifo_entry_t               o_head,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fifo_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
//   Owns the fetch PC, drives the instruction memory address and queues each
//   fetched word with its PC for decode over a valid/ready handshake.
//   Redirects flush the queue and restart fetching at the target.
//   Macro IFU_EXC_EN: enables the fetch address check (misaligned or outside
//   the IM window); a bad fetch queues a nop flagged with out_exc and halts
//   fetching until the next redirect. Without it, out_exc is always 0.
//   Ports:
//     clk, reset_n           clock, asynchronous active-low reset
//     im_addr / im_inst      IM byte address (fetch_pc - IM_BASE) / read data
//     redirect, redirect_pc  restart fetching at redirect_pc
//     out_valid/out_ready    head handshake to decode
//     out_inst/out_pc/out_exc head entry, zero when out_valid=0
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] IM_BASE  = IFU_IM_BASE,
    parameter int          IM_WORDS = IFU_IM_WORDS,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_exc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);
`ifdef IFU_EXC_EN
    localparam logic EXC_EN = 1'b1;
`else
    localparam logic EXC_EN = 1'b0;
`endif

    logic [31:0]   r_fetch_pc;
    logic [0:0]    r_state;

    logic          w_deq;
    logic          w_enq;
    logic          w_addr_bad;
    logic          w_exc;
    logic [CW-1:0] w_count;
    fifo_entry_t   w_push_data;
    fifo_entry_t   w_head;

    assign out_valid = (w_count != '0);
    assign w_deq     = out_valid & out_ready;
    assign w_enq     = !redirect && (r_state == ST_RUN) &&
                       ((w_count < CW'(DEPTH)) || w_deq);

    // 33-bit compare so the upper bound cannot wrap for windows near 4 GiB.
    assign w_addr_bad = (r_fetch_pc[1:0] != 2'b00) ||
                        (r_fetch_pc < IM_BASE) ||
                        ({1'b0, r_fetch_pc} >= IM_END);
    assign w_exc      = EXC_EN & w_addr_bad;

    assign w_push_data.exc  = w_exc;
    assign w_push_data.pc   = r_fetch_pc;
    assign w_push_data.inst = w_exc ? 32'h0 : im_inst;

    assign im_addr = r_fetch_pc - IM_BASE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_state    <= ST_RUN;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_state    <= ST_RUN;
        end else if (w_enq) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_exc) begin
                r_state <= ST_HALT;
            end
        end
    end

    // A same-cycle deq under redirect is irrelevant to the queue: the flush
    // empties it either way, and decode has already consumed the head.
    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_enq),
        .i_pop   (w_deq),
        .i_flush (redirect),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_inst = out_valid ? w_head.inst : 32'h0;
    assign out_pc   = out_valid ? w_head.pc   : 32'h0;
    assign out_exc  = out_valid & EXC_EN & w_head.exc;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_exc;

    int total = 0;
    int bad   = 0;

    ifu_fetch_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .im_addr     (im_addr),
        .im_inst     (im_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_exc     (out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IM word i holds 0x11111111*(i+1), indexed by addr[11:2].
    function automatic logic [31:0] im_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = {22'b0, addr[11:2]};
        return 32'h1111_1111 * (idx + 32'd1);
    endfunction

    always_comb im_inst = im_word(im_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic exc);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_pc"},    out_pc,   pc);
        check({tag, "_inst"},  out_inst, inst);
        check({tag, "_exc"},   {31'b0, out_exc}, {31'b0, exc});
    endtask

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        step();
        step();

        // reset state
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc",    out_pc,   32'h0);
        check("rst_inst",  out_inst, 32'h0);
        check("rst_exc",   {31'b0, out_exc}, 32'd0);
        check("rst_imaddr", im_addr, 32'h0);

        // streaming from reset with out_ready=1
        reset_n = 1'b1;
        step();
        check_head("s0", 32'h3000, 32'h1111_1111, 1'b0);
        step();
        check_head("s1", 32'h3004, 32'h2222_2222, 1'b0);
        step();
        check_head("s2", 32'h3008, 32'h3333_3333, 1'b0);
        step();
        check_head("s3", 32'h300C, 32'h4444_4444, 1'b0);
        check("s3_imaddr", im_addr, 32'h10);

        // stall 5 cycles: one more enq fills the queue, then fetch holds
        out_ready = 1'b0;
        repeat (5) step();
        check_head("stall", 32'h300C, 32'h4444_4444, 1'b0);
        check("stall_imaddr", im_addr, 32'h14);

        // release: gapless, no duplicates
        out_ready = 1'b1;
        step();
        check_head("rel0", 32'h3010, 32'h5555_5555, 1'b0);
        step();
        check_head("rel1", 32'h3014, 32'h6666_6666, 1'b0);
        step();
        check_head("rel2", 32'h3018, 32'h7777_7777, 1'b0);

        // fill queue (head 0x3018, 0x301C behind it), then redirect with ready
        out_ready = 1'b0;
        step();
        check("full_imaddr", im_addr, 32'h20);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect = 1'b0;
        check("redir_gap_valid", {31'b0, out_valid}, 32'd0);
        check("redir_gap_pc", out_pc, 32'h0);
        check("redir_imaddr", im_addr, 32'h100);
        step();
        check_head("redir_tgt", 32'h3100, 32'h5555_5551, 1'b0);
        step();
        check_head("redir_next", 32'h3104, 32'h6666_6662, 1'b0);

        // asynchronous reset mid-stream, away from any edge
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_imaddr", im_addr, 32'h0);
        #1;
        reset_n = 1'b1;
        step();
        check_head("arst_restart", 32'h3000, 32'h1111_1111, 1'b0);

        // out-of-range redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h4000;
        step();
        redirect = 1'b0;
        check("oor_gap_valid", {31'b0, out_valid}, 32'd0);
        step();
`ifdef IFU_EXC_EN
        check_head("oor_head", 32'h4000, 32'h0, 1'b1);
        step();
        check("oor_halt_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("oor_halt_valid2", {31'b0, out_valid}, 32'd0);

        // misaligned target, then recovery
        redirect    = 1'b1;
        redirect_pc = 32'h3002;
        step();
        redirect = 1'b0;
        step();
        check_head("mis_head", 32'h3002, 32'h0, 1'b1);
        step();
        check("mis_halt_valid", {31'b0, out_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h3010;
        step();
        redirect = 1'b0;
        step();
        check_head("resume0", 32'h3010, 32'h5555_5555, 1'b0);
        step();
        check_head("resume1", 32'h3014, 32'h6666_6666, 1'b0);
`else
        check_head("oor_alias", 32'h4000, 32'h1111_1111, 1'b0);
        step();
        check_head("oor_alias1", 32'h4004, 32'h2222_2222, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against an unexpected hang in the directed sequence.
    initial begin
        #20000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
